// File: rtl/control_sequencer.sv
// control_sequencer: Moore control unit for the Mini SRC datapath.
// Steps fetch, decode and execute. Every bus-select, register-enable, memory
// strobe and ALU-op line is decoded from registered state.
//
// Memory handshake: Read/Write stay high from the cycle a memory state is
// entered until the edge where mem_ready=1 is sampled. The state advances on
// that same edge. The wait counter counts edges sampled with mem_ready=0. When
// the counter would reach MEM_TIMEOUT, fault is set and the FSM goes to HALT.
//
// Reset: the first cycle after reset sits in FETCH0 with every strobe low and
// only run high (armed_q=0). Fetch starts on the following cycle.
module control_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  input  logic        stop,
  input  logic        strt,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        Write,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        Cout,
  output logic        HIin,
  output logic        LOin,
  output logic [4:0]  alu_control,
  output logic        run,
  output logic        fault,
  output logic        illegal_op,
  output logic [4:0]  dbg_state
);

  typedef enum logic [4:0] {
    S_FETCH0 = 5'd0,
    S_FETCH1 = 5'd1,
    S_FETCH2 = 5'd2,
    S_DECODE = 5'd3,
    S_ALU3   = 5'd4,
    S_ALU4   = 5'd5,
    S_ALU5   = 5'd6,
    S_IMM3   = 5'd7,
    S_IMM4   = 5'd8,
    S_IMM5   = 5'd9,
    S_MEM3   = 5'd10,
    S_MEM4   = 5'd11,
    S_MEM5   = 5'd12,
    S_LD6    = 5'd13,
    S_LD7    = 5'd14,
    S_ST6    = 5'd15,
    S_ST7    = 5'd16,
    S_MD3    = 5'd17,
    S_MD4    = 5'd18,
    S_MD5    = 5'd19,
    S_MD6    = 5'd20,
    S_HALT   = 5'd21
  } state_e;

  localparam logic [4:0] OP_ALU_LAST = 5'b01000;
  localparam logic [4:0] OP_ADDI     = 5'b01001;
  localparam logic [4:0] OP_ANDI     = 5'b01010;
  localparam logic [4:0] OP_ORI      = 5'b01011;
  localparam logic [4:0] OP_LD       = 5'b01100;
  localparam logic [4:0] OP_ST       = 5'b01101;
  localparam logic [4:0] OP_MUL      = 5'b01110;
  localparam logic [4:0] OP_DIV      = 5'b01111;
  localparam logic [4:0] OP_NOP      = 5'b11010;
  localparam logic [4:0] OP_HALT     = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;

  localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       fault_q, fault_d;
  logic [4:0] op_q, op_d;
  logic       armed_q, armed_d;

  logic [4:0] opcode;
  logic       opcode_legal;
  logic       mem_wait;
  state_e     done_state;
  logic       ir_unused;

  assign opcode       = IR[31:27];
  // Only the opcode field steers the sequencer; the register fields feed the
  // select-encode block outside this module.
  assign ir_unused    = ^IR[26:0];
  assign opcode_legal = (opcode <= OP_DIV) || (opcode == OP_NOP) || (opcode == OP_HALT);
  // The last execute step ends here: stop is sampled only at this boundary.
  assign done_state   = stop ? S_HALT : S_FETCH0;
  assign dbg_state    = state_q;

  // State, wait counter, sticky fault, latched opcode and arm flag.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q    <= S_FETCH0;
      wait_cnt_q <= 8'd0;
      fault_q    <= 1'b0;
      op_q       <= 5'd0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
      op_q       <= op_d;
      armed_q    <= armed_d;
    end
  end

  // Next-state logic, memory wait counting and timeout detection.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    fault_d    = fault_q;
    armed_d    = 1'b1;
    mem_wait   = 1'b0;
    wait_cnt_d = wait_cnt_q;

    case (state_q)
      S_FETCH0: if (armed_q) state_d = S_FETCH1;
      S_FETCH1: if (mem_ready) state_d = S_FETCH2; else mem_wait = 1'b1;
      S_FETCH2: state_d = S_DECODE;
      S_DECODE: begin
        // The opcode is latched so later states decode from registers only.
        op_d = opcode;
        if (opcode <= OP_ALU_LAST)                         state_d = S_ALU3;
        else if (opcode >= OP_ADDI && opcode <= OP_ORI)    state_d = S_IMM3;
        else if (opcode == OP_LD || opcode == OP_ST)       state_d = S_MEM3;
        else if (opcode == OP_MUL || opcode == OP_DIV)     state_d = S_MD3;
        else if (opcode == OP_HALT)                        state_d = S_HALT;
        else                                               state_d = done_state;
      end
      S_ALU3:   state_d = S_ALU4;
      S_ALU4:   state_d = S_ALU5;
      S_ALU5:   state_d = done_state;
      S_IMM3:   state_d = S_IMM4;
      S_IMM4:   state_d = S_IMM5;
      S_IMM5:   state_d = done_state;
      S_MEM3:   state_d = S_MEM4;
      S_MEM4:   state_d = S_MEM5;
      S_MEM5:   state_d = (op_q == OP_ST) ? S_ST6 : S_LD6;
      S_LD6:    if (mem_ready) state_d = S_LD7; else mem_wait = 1'b1;
      S_LD7:    state_d = done_state;
      S_ST6:    state_d = S_ST7;
      S_ST7:    if (mem_ready) state_d = done_state; else mem_wait = 1'b1;
      S_MD3:    state_d = S_MD4;
      S_MD4:    state_d = S_MD5;
      S_MD5:    state_d = S_MD6;
      S_MD6:    state_d = done_state;
      S_HALT:   if (strt) state_d = S_FETCH0;
      default:  state_d = S_FETCH0;
    endcase

    if (mem_wait && (({1'b0, wait_cnt_q} + 9'd1) >= TIMEOUT_LIM)) begin
      state_d = S_HALT;
      fault_d = 1'b1;
    end

    if (state_d != state_q) wait_cnt_d = 8'd0;
    else if (mem_wait)      wait_cnt_d = wait_cnt_q + 8'd1;
  end

  // Moore output decode; all strobes default low, alu_control defaults to add.
  always_comb begin
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0;
    MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
    Read = 1'b0; Write = 1'b0;
    IRin = 1'b0; Yin = 1'b0; Zin = 1'b0;
    Zlowout = 1'b0; Zhighout = 1'b0; Cout = 1'b0;
    HIin = 1'b0; LOin = 1'b0;
    alu_control = ALU_ADD;
    run         = (state_q != S_HALT);
    fault       = fault_q;
    // Only output that also depends on IR: it flags the opcode currently
    // being decoded, in the single DECODE cycle.
    illegal_op  = (state_q == S_DECODE) && !opcode_legal;

    if (armed_q) begin
      case (state_q)
        S_FETCH0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
        S_FETCH1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
        S_FETCH2: begin MDRout = 1'b1; IRin = 1'b1; end
        S_ALU3, S_IMM3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        S_ALU4: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_control = op_q; end
        S_IMM4: begin
          Cout = 1'b1; Zin = 1'b1;
          case (op_q)
            OP_ANDI: alu_control = ALU_AND;
            OP_ORI:  alu_control = ALU_OR;
            default: alu_control = ALU_ADD;
          endcase
        end
        S_ALU5, S_IMM5: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        S_MEM3: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
        S_MEM4: begin Cout = 1'b1; Zin = 1'b1; end
        S_MEM5: begin Zlowout = 1'b1; MARin = 1'b1; end
        S_LD6:  begin Read = 1'b1; MDRin = 1'b1; end
        S_LD7:  begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        S_ST6:  begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
        S_ST7:  Write = 1'b1;
        S_MD3:  begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        // The multiply/divide operation code is driven while Z captures the result.
        S_MD4:  begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_control = op_q; end
        S_MD5:  begin Zlowout = 1'b1; LOin = 1'b1; end
        S_MD6:  begin Zhighout = 1'b1; HIin = 1'b1; end
        default: ;
      endcase
    end
  end

endmodule
